// File: rtl/riscv_tag_check_if.sv
// CSR, propagation and check-point signals between the RI5CY core and the DIFT tag check unit.
// The core drives through master; the unit consumes through slave.
interface riscv_tag_check_if #(
  parameter int TAG_WIDTH   = 1,
  parameter int NUM_CLASSES = 7,
  parameter int NUM_CHECKS  = 22
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                  csr_access_i;
  logic [1:0]            csr_op_i;
  logic [1:0]            csr_addr_i;
  logic [31:0]           csr_wdata_i;
  logic [31:0]           csr_rdata_o;
  logic [CLS_W-1:0]      prop_class_i;
  logic [TAG_WIDTH-1:0]  tag_a_i;
  logic [TAG_WIDTH-1:0]  tag_b_i;
  logic [TAG_WIDTH-1:0]  tag_old_i;
  logic [TAG_WIDTH-1:0]  tag_res_o;
  logic                  chk_valid_i;
  logic [NUM_CHECKS-1:0] chk_pts_i;
  logic [31:0]           chk_pc_i;
  logic                  exc_req_o;
  logic                  exc_ack_i;

  modport master (
    output csr_access_i, csr_op_i, csr_addr_i, csr_wdata_i, prop_class_i,
           tag_a_i, tag_b_i, tag_old_i, chk_valid_i, chk_pts_i, chk_pc_i, exc_ack_i,
    input  csr_rdata_o, tag_res_o, exc_req_o
  );

  modport slave (
    input  csr_access_i, csr_op_i, csr_addr_i, csr_wdata_i, prop_class_i,
           tag_a_i, tag_b_i, tag_old_i, chk_valid_i, chk_pts_i, chk_pc_i, exc_ack_i,
    output csr_rdata_o, tag_res_o, exc_req_o
  );
endinterface

// File: rtl/riscv_tag_check_unit.sv
// DIFT policy/enforcement unit: programmable TPR/TCR, tag combiner, violation log FIFO,
// saturating violation counter and a held exception request toward the controller.
module riscv_tag_check_unit #(
  parameter int TAG_WIDTH   = 1,
  parameter int NUM_CLASSES = 7,
  parameter int NUM_CHECKS  = 22,
  parameter int LOG_DEPTH   = 4,
  parameter int CNT_WIDTH   = 12
) (
  input logic              clk,
  input logic              rst,
  riscv_tag_check_if.slave bus
);
  localparam int TPR_W = 2 * NUM_CLASSES;
  localparam int PW    = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLEAR = 2'b11;
  localparam logic [1:0] A_TPR = 2'd0, A_TCR = 2'd1, A_STATUS = 2'd2, A_LOG = 2'd3;

  typedef enum logic {IDLE, PEND} state_e;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] pc;
  } log_entry_t;

  logic [TPR_W-1:0]      tpr_q;
  logic [NUM_CHECKS-1:0] tcr_q;
  log_entry_t            mem [LOG_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [4:0]            occ_q, occ_after;
  logic                  ovf_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  state_e                state_q, state_d;

  function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old_v,
                                            input logic [31:0] wd);
    case (op)
      OP_WRITE: csr_apply = wd;
      OP_SET:   csr_apply = old_v | wd;
      OP_CLEAR: csr_apply = old_v & ~wd;
      default:  csr_apply = old_v;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(LOG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] tpr_nxt, tcr_nxt;
  logic        tpr_we, tcr_we, stat_clr, log_pop, log_push, log_drop, viol;
  logic [NUM_CHECKS-1:0] hits;
  logic [4:0]  viol_idx;
  log_entry_t  head;

  assign tpr_nxt  = csr_apply(bus.csr_op_i, 32'(tpr_q), bus.csr_wdata_i);
  assign tcr_nxt  = csr_apply(bus.csr_op_i, 32'(tcr_q), bus.csr_wdata_i);
  assign tpr_we   = bus.csr_access_i && bus.csr_addr_i == A_TPR;
  assign tcr_we   = bus.csr_access_i && bus.csr_addr_i == A_TCR;
  assign stat_clr = bus.csr_access_i && bus.csr_addr_i == A_STATUS && bus.csr_op_i == OP_WRITE;

  // Class decode by match loop so an out-of-range class never aliases a TPR field.
  always_comb begin
    bus.tag_res_o = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (int'(bus.prop_class_i) == c) begin
        case (tpr_q[2*c +: 2])
          2'b00:   bus.tag_res_o = bus.tag_old_i;
          2'b01:   bus.tag_res_o = bus.tag_a_i & bus.tag_b_i;
          2'b10:   bus.tag_res_o = bus.tag_a_i | bus.tag_b_i;
          default: bus.tag_res_o = '0;
        endcase
      end
    end
  end

  assign hits = bus.chk_pts_i & tcr_q;
  assign viol = bus.chk_valid_i && |hits;

  // Descending scan so the lowest enabled check point ends up as the logged index.
  always_comb begin
    viol_idx = '0;
    for (int k = NUM_CHECKS - 1; k >= 0; k--)
      if (hits[k]) viol_idx = 5'(k);
  end

  // The pop is accounted first, so a full FIFO can still accept a same-cycle violation.
  assign log_pop   = bus.csr_access_i && bus.csr_addr_i == A_LOG && occ_q != '0;
  assign occ_after = occ_q - 5'(log_pop);
  assign log_push  = viol && occ_after != 5'(LOG_DEPTH);
  assign log_drop  = viol && !log_push;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      tpr_q   <= '0;
      tcr_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (tpr_we)   tpr_q  <= tpr_nxt[TPR_W-1:0];
      if (tcr_we)   tcr_q  <= tcr_nxt[NUM_CHECKS-1:0];
      if (log_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (log_push) wr_ptr <= ptr_inc(wr_ptr);
      occ_q <= occ_after + 5'(log_push);
      if (stat_clr)      ovf_q <= 1'b0;
      else if (log_drop) ovf_q <= 1'b1;
      if (stat_clr)                   cnt_q <= '0;
      else if (viol && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && log_push) mem[wr_ptr] <= '{idx: viol_idx, pc: bus.chk_pc_i};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (viol) state_d = PEND;
      PEND:    if (bus.exc_ack_i && !viol) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.exc_req_o = (state_q == PEND);
  end

  always_comb begin
    bus.csr_rdata_o = '0;
    case (bus.csr_addr_i)
      A_TPR: bus.csr_rdata_o = 32'(tpr_q);
      A_TCR: bus.csr_rdata_o = 32'(tcr_q);
      A_STATUS: begin
        bus.csr_rdata_o[4:0]   = (occ_q != '0) ? head.idx : 5'd0;
        bus.csr_rdata_o[12:8]  = occ_q;
        bus.csr_rdata_o[15]    = bus.exc_req_o;
        bus.csr_rdata_o[16]    = ovf_q;
        bus.csr_rdata_o[31:20] = 12'(cnt_q);
      end
      default: bus.csr_rdata_o = (occ_q != '0) ? head.pc : 32'd0;
    endcase
  end
endmodule

// File: doc/riscv_tag_check_unit.md
# riscv_tag_check_unit

Parametrised DIFT policy and enforcement unit for the RI5CY core. It replaces the fixed single-bit tag propagation/check constants with programmable state:
- a Tag Propagation Register (TPR) and Tag Check Register (TCR) written over the CSR port;
- a TAG_WIDTH-bit propagation combiner;
- a violation detector feeding a PC log FIFO, a saturating violation counter and a held exception-request handshake toward the controller.

It sits beside the CSR file, fed by the EX stage.

## Interface
- TAG_WIDTH, 1: tag bits per register/word.
- NUM_CLASSES, 7: propagation classes (integer, branch, jump, shift, comparison, logical, load/store); class index = TPR field index.
- NUM_CHECKS, 22: check points; bit k of TCR enables check k (0..21 per core check map, 21 = execute-PC). Max 32.
- LOG_DEPTH, 4: violation log entries, 1..31.
- CNT_WIDTH, 12: violation counter width, max 12.
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- csr_access_i  in  1  CSR access to this unit this cycle.
- csr_op_i  in  2  00 NONE, 01 WRITE, 10 SET, 11 CLEAR.
- csr_addr_i  in  2  0 TPR, 1 TCR, 2 STATUS, 3 LOG.
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  read data, combinational.
- prop_class_i  in  $clog2(NUM_CLASSES)  class of current instruction.
- tag_a_i, tag_b_i, tag_old_i  in  TAG_WIDTH  source tags, old destination tag.
- tag_res_o  out  TAG_WIDTH  propagated destination tag, combinational.
- chk_valid_i  in  1  EX instruction valid for checking.
- chk_pts_i  in  NUM_CHECKS  check points whose tag is non-zero.
- chk_pc_i  in  32  PC of checked instruction.
- exc_req_o  out  1  tag-violation exception request.
- exc_ack_i  in  1  controller accepts request.

## Operation
- TPR: 2*NUM_CLASSES bits, field c = bits [2c+1:2c]. Reset 0. TCR: NUM_CHECKS bits, reset 0. Unused high bits read 0 and ignore writes.
- CSR writes to TPR/TCR: WRITE reg=wdata; SET reg|=wdata; CLEAR reg&=~wdata; NONE no change.
- Propagation per field of prop_class_i:
  - 00 OLD: tag_res_o = tag_old_i.
  - 01 AND: tag_res_o = tag_a_i & tag_b_i.
  - 10 OR: tag_res_o = tag_a_i | tag_b_i.
  - 11 CLEAR: tag_res_o = 0.
  - Out-of-range class gives 0.
- Violation: viol = chk_valid_i & |(chk_pts_i & TCR). Index = lowest set bit of (chk_pts_i & TCR), 5 bits.
- Log FIFO: entry {idx[4:0], pc[31:0]}.
  - Violation pushes if not full after this cycle's pop; otherwise sets sticky overflow and drops the entry.
  - Every violation increments the counter, saturating at 2^CNT_WIDTH-1.
- STATUS read:
  - [4:0] head idx (0 if empty).
  - [12:8] occupancy.
  - [15] exc_req_o.
  - [16] overflow.
  - [31:20] counter, zero-extended.
- STATUS write: WRITE clears overflow and counter. SET/CLEAR are ignored.
- LOG read:
  - Any csr_access_i with addr 3 returns head PC and pops it.
  - Empty returns 0, no pop.
  - Writes to LOG ignored.
- Exception FSM, states IDLE/PEND:
  - IDLE->PEND on viol.
  - PEND->IDLE on exc_ack_i without a new viol.
  - PEND with ack and new viol stays PEND.
  - exc_req_o = (state==PEND). Ack in IDLE ignored.

## Timing
- Reset, synchronous: TPR=0, TCR=0, log empty, overflow=0, counter=0, FSM IDLE, exc_req_o=0. rst overrides all same-cycle pushes, pops and writes.
- csr_rdata_o, tag_res_o: combinational, same cycle.
- CSR write takes effect next edge. A same-cycle check or propagation uses the old TPR/TCR.
- exc_req_o rises the cycle after the violating chk_valid_i and holds until the edge after exc_ack_i.
- Full FIFO with simultaneous pop and violation: both happen, no overflow.
- Empty FIFO with simultaneous LOG read and violation: read returns 0 (no bypass), entry pushed, occupancy 1.
- Same-cycle STATUS WRITE and violation: the clear wins for the counter, the violation is still logged. The clear also wins for overflow when the FIFO is full.
- Read pointer wraps modulo LOG_DEPTH.

## Test plan
- Reset, then read all CSRs -> TPR=0, TCR=0, STATUS=0, LOG=0, exc_req_o=0.
- TPR WRITE 0x2 (integer=OR), class 0, a=1, b=0, old=0 -> tag_res_o=1. TPR CLEAR 0x2, then SET 0x1 (AND) -> tag_res_o=0.
- TCR WRITE 0x6, chk_pts_i=0x4, pc=0x100 -> exc_req_o=1 next cycle; STATUS idx=2, occ=1, cnt=1. LOG read -> 0x100, occ=0. Ack -> exc_req_o=0 next cycle.
- LOG_DEPTH=4, 5 back-to-back violations -> occ=4, overflow=1, cnt=5, first four PCs read in order. STATUS WRITE -> overflow=0, cnt=0.
- Full FIFO, pop and violation same cycle -> occ stays 4, overflow 0, new PC last. Ack and new violation same cycle -> exc_req_o stays 1.
- chk_pts_i=0x4 with TCR=0x2 -> no request, cnt unchanged. rst mid-PEND with 2 entries -> all state back to reset values next cycle.
